// File: rtl/noc_vc_link_arbiter_if.sv
// Link bundle between per-VC flit sources, the VC arbiter and the downstream
// multi-channel flit FIFO. Signal names are seen from the arbiter.
interface noc_vc_link_arbiter_if #(
    parameter int CHANNELS   = 4,
    parameter int FLIT_WIDTH = 32
);
    logic [CHANNELS-1:0]                 i_valid;
    logic [CHANNELS-1:0][FLIT_WIDTH-1:0] i_flit;
    logic [CHANNELS-1:0]                 o_ready;
    logic [CHANNELS-1:0]                 o_valid;
    logic [FLIT_WIDTH-1:0]               o_flit;
    logic [CHANNELS-1:0]                 i_ready;
    logic [CHANNELS-1:0]                 i_vc_ready;
    logic                                o_locked;

    // Arbiter side
    modport slave (
        input  i_valid, i_flit, i_ready, i_vc_ready,
        output o_ready, o_valid, o_flit, o_locked
    );

    // Environment side (sources + downstream FIFO)
    modport master (
        output i_valid, i_flit, i_ready, i_vc_ready,
        input  o_ready, o_valid, o_flit, o_locked
    );
endinterface

// File: rtl/noc_vc_link_arbiter.sv
// Per-flit round-robin VC arbiter with a single-slot link register and
// optional packet locking (grant held on one VC until its tail flit).
module noc_vc_link_arbiter #(
    parameter int CHANNELS    = 4,
    parameter int FLIT_WIDTH  = 32,
    parameter int TAIL_BIT    = FLIT_WIDTH - 1,
    parameter bit LOCK_PACKET = 1'b1
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    noc_vc_link_arbiter_if.slave  link
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]   valid_q, valid_d;
    logic [FLIT_WIDTH-1:0] flit_q, flit_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic                  locked_q, locked_d;
    logic [IDX_W-1:0]      lock_vc_q, lock_vc_d;

    logic                  fire, load_en, found, load;
    logic [IDX_W-1:0]      grant;
    logic [CHANNELS-1:0]   elig_raw, elig, lock_mask, grant_oh;

    // Per-lane eligibility: valid upstream and room downstream
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign elig_raw[c] = link.i_valid[c] & link.i_vc_ready[c];
    end

    assign fire    = |(valid_q & link.i_ready);
    assign load_en = ~(|valid_q) | fire;

    // While locked only the owning VC may compete, even if it is idle
    always_comb begin
        lock_mask = '1;
        if (locked_q) begin
            lock_mask            = '0;
            lock_mask[lock_vc_q] = 1'b1;
        end
    end

    assign elig = elig_raw & lock_mask;

    // Round-robin search starting one past the last granted VC
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        grant = ptr_q;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(ptr_q) + k) % CHANNELS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

    assign load = load_en & found & ~noc_rst;

    // One-hot of the grant, gated so nothing is popped unless it loads
    always_comb begin
        grant_oh = '0;
        if (load) grant_oh[grant] = 1'b1;
    end

    assign link.o_ready  = grant_oh;
    assign link.o_valid  = valid_q;
    assign link.o_flit   = flit_q;
    assign link.o_locked = locked_q;

    // Next state for the link slot, RR pointer and packet lock
    always_comb begin
        valid_d   = valid_q;
        flit_d    = flit_q;
        ptr_d     = ptr_q;
        locked_d  = locked_q;
        lock_vc_d = lock_vc_q;
        if (load) begin
            valid_d = grant_oh;
            flit_d  = link.i_flit[grant];
            ptr_d   = grant;
            if (LOCK_PACKET) begin
                if (!locked_q && !link.i_flit[grant][TAIL_BIT]) begin
                    locked_d  = 1'b1;
                    lock_vc_d = grant;
                end else if (locked_q && link.i_flit[grant][TAIL_BIT]) begin
                    // grant can only be lock_vc here because of the mask
                    locked_d = 1'b0;
                end
            end
        end else if (fire) begin
            valid_d = '0;
        end
        if (!LOCK_PACKET) locked_d = 1'b0;
    end

    // State registers with synchronous reset
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            valid_q   <= '0;
            flit_q    <= '0;
            ptr_q     <= IDX_W'(CHANNELS - 1);
            locked_q  <= 1'b0;
            lock_vc_q <= '0;
        end else begin
            valid_q   <= valid_d;
            flit_q    <= flit_d;
            ptr_q     <= ptr_d;
            locked_q  <= locked_d;
            lock_vc_q <= lock_vc_d;
        end
    end
endmodule

// File: tb/tb_noc_vc_link_arbiter.sv
// Directed bench: two arbiters (packet lock off / on) share one stimulus.
// Grants accepted before an edge are queued and compared once on the link.
module tb_noc_vc_link_arbiter;
    localparam int CH = 4;
    localparam int FW = 16;

    logic noc_clk = 1'b0;
    logic noc_rst;
    always #5 noc_clk = ~noc_clk;

    noc_vc_link_arbiter_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) l0 ();
    noc_vc_link_arbiter_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) l1 ();

    logic [CH-1:0]         vld, rdy, vrdy, tail;
    logic [CH-1:0][FW-1:0] flit;
    logic [7:0]            seq [CH];

    assign l0.i_valid = vld;  assign l1.i_valid = vld;
    assign l0.i_flit  = flit; assign l1.i_flit  = flit;
    assign l0.i_ready = rdy;  assign l1.i_ready = rdy;
    assign l0.i_vc_ready = vrdy; assign l1.i_vc_ready = vrdy;

    noc_vc_link_arbiter #(.CHANNELS(CH), .FLIT_WIDTH(FW), .TAIL_BIT(FW-1), .LOCK_PACKET(1'b0))
        u0 (.noc_clk(noc_clk), .noc_rst(noc_rst), .link(l0.slave));
    noc_vc_link_arbiter #(.CHANNELS(CH), .FLIT_WIDTH(FW), .TAIL_BIT(FW-1), .LOCK_PACKET(1'b1))
        u1 (.noc_clk(noc_clk), .noc_rst(noc_rst), .link(l1.slave));

    typedef struct {
        int            vc;
        logic [FW-1:0] flit;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   cur_v;
    bit   chk0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_tot  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mkflit(input int c);
        return {tail[c], 3'b000, 4'(c), seq[c]};
    endfunction

    // One cycle: g = expected grant (-1 none), lk = expected lock after the edge
    task automatic step(input int g, input bit lk);
        logic [CH-1:0] exp_r;
        logic [CH-1:0] exp_v;
        bit            fire;
        exp_t          e;
        for (int c = 0; c < CH; c++) flit[c] = mkflit(c);
        #1;
        exp_r = '0;
        if (g >= 0) exp_r[g] = 1'b1;
        chk("ready_lock", 64'(l1.o_ready), 64'(exp_r));
        if (chk0) chk("ready_nolock", 64'(l0.o_ready), 64'(exp_r));
        fire = cur_v && rdy[cur.vc];
        if (g >= 0) begin
            e.vc   = g;
            e.flit = flit[g];
            sb.push_back(e);
        end
        @(posedge noc_clk);
        #1;
        if (g >= 0) begin
            if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
            else begin
                cur   = sb.pop_front();
                cur_v = 1'b1;
            end
            seq[g] = seq[g] + 8'd1;
        end else if (fire) begin
            cur_v = 1'b0;
        end
        exp_v = '0;
        if (cur_v) exp_v[cur.vc] = 1'b1;
        chk("valid_lock", 64'(l1.o_valid), 64'(exp_v));
        if (cur_v) chk("flit_lock", 64'(l1.o_flit), 64'(cur.flit));
        chk("locked_lock", 64'(l1.o_locked), 64'(lk));
        if (chk0) begin
            chk("valid_nolock", 64'(l0.o_valid), 64'(exp_v));
            if (cur_v) chk("flit_nolock", 64'(l0.o_flit), 64'(cur.flit));
        end
        chk("locked_nolock", 64'(l0.o_locked), 64'd0);
        @(negedge noc_clk);
    endtask

    task automatic rst_cycle();
        noc_rst = 1'b1;
        #1;
        chk("rst_ready_lock", 64'(l1.o_ready), 64'd0);
        chk("rst_ready_nolock", 64'(l0.o_ready), 64'd0);
        @(posedge noc_clk);
        #1;
        chk("rst_valid_lock", 64'(l1.o_valid), 64'd0);
        chk("rst_flit_lock", 64'(l1.o_flit), 64'd0);
        chk("rst_locked_lock", 64'(l1.o_locked), 64'd0);
        chk("rst_valid_nolock", 64'(l0.o_valid), 64'd0);
        chk("rst_flit_nolock", 64'(l0.o_flit), 64'd0);
        cur_v = 1'b0;
        sb.delete();
        @(negedge noc_clk);
    endtask

    initial begin
        noc_rst = 1'b1;
        vld  = 4'b1111;
        rdy  = 4'b1111;
        vrdy = 4'b1111;
        tail = 4'b1111;
        for (int c = 0; c < CH; c++) seq[c] = 8'd0;
        for (int c = 0; c < CH; c++) flit[c] = mkflit(c);
        cur_v = 1'b0;
        chk0  = 1'b1;
        @(negedge noc_clk);

        // Reset with every VC requesting: nothing popped, link empty
        rst_cycle();
        rst_cycle();
        noc_rst = 1'b0;

        // Round-robin from VC0 with everything ready
        step(0, 0); step(1, 0); step(2, 0); step(3, 0); step(0, 0); step(1, 0);

        // Downstream stall on VC1: slot holds, nothing popped
        rdy = 4'b1101;
        step(-1, 0); step(-1, 0); step(-1, 0);
        // Release: fire and reload on the same edge
        rdy = 4'b1111;
        step(2, 0); step(3, 0);

        // VC2 almost full: skipped in the rotation
        vrdy = 4'b1011;
        step(0, 0); step(1, 0); step(3, 0); step(0, 0); step(1, 0); step(3, 0);
        vrdy = 4'b1111;

        // Drain
        vld = 4'b0000;
        step(-1, 0);

        // Packet lock on VC2 while VC0 keeps requesting (lock-off copy not tracked)
        chk0 = 1'b0;
        vld  = 4'b0101;
        tail = 4'b1011;
        step(0, 0);      // VC0 single-flit packet
        step(2, 1);      // VC2 head -> lock
        vld = 4'b0001;
        step(-1, 1);     // VC2 idle, VC0 still blocked
        vld = 4'b0101;
        step(2, 1);      // body
        tail[2] = 1'b1;
        step(2, 0);      // tail releases the lock
        step(0, 0);      // VC0 finally granted

        // Reset in the middle of a VC1 packet
        vld  = 4'b0010;
        tail = 4'b1101;
        step(1, 1);
        rst_cycle();
        noc_rst = 1'b0;
        chk0 = 1'b1;
        vld  = 4'b1111;
        tail = 4'b1111;
        step(0, 0); step(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
